// File: rtl/i2s_slave_tx_if.sv
// Bus bundle for i2s_slave_tx: master clocks, sample handshake and serial output.
// underrun_cnt exists only when I2S_TX_UNDERRUN_CNT_EN is defined.
interface i2s_slave_tx_if #(
  parameter int unsigned DATA_W = 16
);
  logic              SCLK;
  logic              LRCLK;
  logic [DATA_W-1:0] smpl_lft;
  logic [DATA_W-1:0] smpl_rht;
  logic              smpl_vld;
  logic              smpl_rdy;
  logic              SDout;
  logic              underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0]        underrun_cnt;

  modport slave (
    input  SCLK, LRCLK, smpl_lft, smpl_rht, smpl_vld,
    output smpl_rdy, SDout, underrun, underrun_cnt
  );
  modport master (
    output SCLK, LRCLK, smpl_lft, smpl_rht, smpl_vld,
    input  smpl_rdy, SDout, underrun, underrun_cnt
  );
`else
  modport slave (
    input  SCLK, LRCLK, smpl_lft, smpl_rht, smpl_vld,
    output smpl_rdy, SDout, underrun
  );
  modport master (
    output SCLK, LRCLK, smpl_lft, smpl_rht, smpl_vld,
    input  smpl_rdy, SDout, underrun
  );
`endif
endinterface

// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: serialises buffered stereo pairs on SDout against external SCLK/LRCLK.
// Optional saturating underrun counter enabled by macro I2S_TX_UNDERRUN_CNT_EN.
module i2s_slave_tx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SLOT_W = 24
) (
  input  logic          clk,
  input  logic          RST_n,
  i2s_slave_tx_if.slave bus
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sclk_sync, lr_sync;
  logic              sclk_prev, lr_prev;
  logic              sclk_fall, lr_fall, lr_rise;
  logic [DATA_W-1:0] buf_lft, buf_rht;
  logic [DATA_W-1:0] tx_lft, tx_rht, tx_lft_d, tx_rht_d;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rdy_q, sd_q, ur_q;
  logic              start_left, start_right, shift_bit;
  logic              accept, load_buf, underrun_d;

  // Two-flop synchronisers plus a registered edge pulse; LRCLK chain resets low so
  // a released reset can only produce a spurious rise, which SYNC ignores.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sclk_sync <= 2'b00;
      lr_sync   <= 2'b00;
      sclk_prev <= 1'b0;
      lr_prev   <= 1'b0;
      sclk_fall <= 1'b0;
      lr_fall   <= 1'b0;
      lr_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.SCLK};
      lr_sync   <= {lr_sync[0], bus.LRCLK};
      sclk_prev <= sclk_sync[1];
      lr_prev   <= lr_sync[1];
      sclk_fall <= sclk_prev & ~sclk_sync[1];
      lr_fall   <= lr_prev & ~lr_sync[1];
      lr_rise   <= ~lr_prev & lr_sync[1];
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Slot sequencing and left-frame pair selection
  always_comb begin
    state_d     = state_q;
    start_left  = 1'b0;
    start_right = 1'b0;
    load_buf    = 1'b0;
    underrun_d  = 1'b0;
    tx_lft_d    = tx_lft;
    tx_rht_d    = tx_rht;
    case (state_q)
      SYNC: begin
        if (lr_fall) begin
          state_d    = LEFT;
          start_left = 1'b1;
        end
      end
      LEFT: begin
        if (lr_rise) begin
          state_d     = RIGHT;
          start_right = 1'b1;
        end
      end
      RIGHT: begin
        if (lr_fall) begin
          state_d    = LEFT;
          start_left = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
    if (start_left) begin
      if (!rdy_q) begin
        load_buf = 1'b1;
        tx_lft_d = buf_lft;
        tx_rht_d = buf_rht;
      end else if (bus.smpl_vld) begin
        tx_lft_d = bus.smpl_lft;
        tx_rht_d = bus.smpl_rht;
      end else begin
        underrun_d = 1'b1;
      end
    end
    accept    = bus.smpl_vld & rdy_q & ~start_left;
    shift_bit = (state_q != SYNC) & sclk_fall & ~start_left & ~start_right;
  end

  // Holding buffer and transmit pair
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rdy_q   <= 1'b1;
      buf_lft <= '0;
      buf_rht <= '0;
      tx_lft  <= '0;
      tx_rht  <= '0;
      ur_q    <= 1'b0;
    end else begin
      if (load_buf)    rdy_q <= 1'b1;
      else if (accept) rdy_q <= 1'b0;
      if (accept) begin
        buf_lft <= bus.smpl_lft;
        buf_rht <= bus.smpl_rht;
      end
      tx_lft <= tx_lft_d;
      tx_rht <= tx_rht_d;
      ur_q   <= underrun_d;
    end
  end

  // Serialiser: slot start reloads, each later SCLK fall drives one bit until SLOT_W
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sd_q    <= 1'b0;
    end else if (start_left) begin
      shreg   <= tx_lft_d;
      bit_cnt <= '0;
    end else if (start_right) begin
      shreg   <= tx_rht;
      bit_cnt <= '0;
    end else if (shift_bit) begin
      if (bit_cnt < CNT_W'(SLOT_W)) begin
        sd_q    <= shreg[DATA_W-1];
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        sd_q <= 1'b0;
      end
    end
  end

  assign bus.smpl_rdy = rdy_q;
  assign bus.SDout    = sd_q;
  assign bus.underrun = ur_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] ur_cnt;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)                             ur_cnt <= 8'd0;
    else if (underrun_d && ur_cnt != 8'hFF) ur_cnt <= ur_cnt + 8'd1;
  end

  assign bus.underrun_cnt = ur_cnt;
`endif

endmodule
